// File: rtl/lcd_cmd_host_if.sv
// Command-path bundle between the upstream sequencer, the LCD command host and the LCD controller.
// The master modport is the host side; the slave modport is the environment (sequencer + controller).
interface lcd_cmd_host_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [2:0]    push_cmd;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic          done;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic          finished;
    logic          timeout;

    modport master (
        input  push, push_cmd, busy, done,
        output full, count, overflow, cmd, cmd_valid, finished, timeout
    );

    modport slave (
        output push, push_cmd, busy, done,
        input  full, count, overflow, cmd, cmd_valid, finished, timeout
    );
endinterface

// File: rtl/lcd_cmd_host.sv
// LCD controller command initiator: queues 3-bit image commands and strobes them out one at a time,
// then watches for write completion and latches finished or timeout until the next reset.
module lcd_cmd_host #(
    parameter int DEPTH   = 8,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 128
) (
    input  logic           clk,
    input  logic           reset,
    lcd_cmd_host_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [2:0]    GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
    localparam bit            HAS_GAP  = (GAP > 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_READY = 3'd0,
        S_READY      = 3'd1,
        S_ISSUE      = 3'd2,
        S_GAP        = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_HALT       = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          overflow_q, overflow_d;
    logic          finished_q, finished_d;
    logic          timeout_q, timeout_d;
    logic [2:0]    gap_cnt_q, gap_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          pop_s;
    logic          push_ok_s;
    logic          empty_s;
    logic          full_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == DEPTH_C);

    // Sequencer: issue, gap spacing, write completion tracking.
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        finished_d  = finished_q;
        timeout_d   = timeout_q;
        gap_cnt_d   = gap_cnt_q;
        to_cnt_d    = to_cnt_q;
        case (state_q)
            S_WAIT_READY: begin
                if (!bus.busy) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_WAIT_READY;
                end
            end
            S_READY: begin
                if (!empty_s && !bus.busy) begin
                    pop_s       = 1'b1;
                    cmd_d       = mem_q[rd_ptr_q];
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_READY;
                end
            end
            S_ISSUE: begin
                // The strobe cycle counts as cycle 0 of the completion window.
                if (cmd_q == 3'd0) begin
                    to_cnt_d = TW'(1);
                    state_d  = S_WAIT_DONE;
                end else if (HAS_GAP) begin
                    gap_cnt_d = 3'd0;
                    state_d   = S_GAP;
                end else begin
                    state_d = S_READY;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_READY;
                end else begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.done) begin
                    finished_d = 1'b1;
                    state_d    = S_HALT;
                end else if (to_cnt_q >= TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_WAIT_READY;
            end
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO is accepted only when a pop frees a slot.
    always_comb begin
        push_ok_s  = bus.push && (!full_s || pop_s);
        overflow_d = overflow_q | (bus.push && full_s && !pop_s);
        wr_ptr_d   = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_READY;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            finished_q  <= 1'b0;
            timeout_q   <= 1'b0;
            gap_cnt_q   <= 3'd0;
            to_cnt_q    <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            overflow_q  <= overflow_d;
            finished_q  <= finished_d;
            timeout_q   <= timeout_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= bus.push_cmd;
        end
    end

    assign bus.full      = full_s;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.finished  = finished_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: scenario tasks with randomized command codes, checked against a
// queue model of the command stream and timing rules derived from the host's handshake protocol.
module tb_lcd_cmd_host;
    localparam int DEPTH   = 8;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 128;

    logic clk = 1'b0;
    logic reset;

    lcd_cmd_host_if #(.DEPTH(DEPTH)) bus ();

    lcd_cmd_host #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         inv_err = 0;
    logic [2:0] obs_q[$];
    int         obs_cyc[$];
    logic       prev_valid = 1'b0;
    logic [2:0] prev_cmd   = 3'd0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample after the edge, log strobes, track strobe-width and cmd-stability rules.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.cmd_valid === 1'b1) begin
            obs_q.push_back(bus.cmd);
            obs_cyc.push_back(cyc);
            if (prev_valid === 1'b1) inv_err++;
        end else if (bus.cmd !== prev_cmd) begin
            inv_err++;
        end
        prev_valid = bus.cmd_valid;
        prev_cmd   = bus.cmd;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.push     = 1'b0;
        bus.push_cmd = 3'd0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        prev_valid = 1'b0;
        prev_cmd   = 3'd0;
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_strobe(input int limit, input bit want_write, output int s, output bit ok);
        ok = 1'b0;
        s  = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (bus.cmd_valid === 1'b1 && (!want_write || bus.cmd === 3'd0)) begin
                ok = 1'b1;
                s  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.busy = 1'b1;
        bus.done = 1'b0;
        #3;
        checks++;
        if (bus.count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        checks++;
        if ({bus.full, bus.overflow, bus.cmd_valid, bus.finished, bus.timeout, bus.cmd} !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: got full=%b ovf=%b vld=%b fin=%b to=%b cmd=%0d expected all 0",
                     bus.full, bus.overflow, bus.cmd_valid, bus.finished, bus.timeout, bus.cmd);
        end
        apply_reset();
    endtask

    task automatic test_busy_hold();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            bus.push     = (i == 3);
            bus.push_cmd = 3'd4;
            tick();
        end
        bus.push = 1'b0;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL busy_no_strobe: got %0d strobes expected 0", obs_q.size());
        end
        checks++;
        if (bus.count !== 4'd1) begin
            errors++;
            $display("FAIL busy_count: got %0d expected 1", bus.count);
        end
        bus.busy = 1'b0;
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_early_strobe: got %b expected 0", bus.cmd_valid);
        end
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd4) begin
            errors++;
            $display("FAIL busy_strobe: got vld=%b cmd=%0d expected vld=1 cmd=4", bus.cmd_valid, bus.cmd);
        end
        checks++;
        if (bus.count !== 4'd0) begin
            errors++;
            $display("FAIL busy_count_after: got %0d expected 0", bus.count);
        end
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_strobe_width: got %b expected 0", bus.cmd_valid);
        end
    endtask

    task automatic test_gap();
        int p;
        apply_reset();
        bus.busy = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 3; i++) begin
            bus.push     = 1'b1;
            bus.push_cmd = 3'(i);
            tick();
            if (i == 1) p = cyc;
        end
        bus.push = 1'b0;
        repeat (20) tick();
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL gap_count: got %0d strobes expected 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== 3'(i + 1)) begin
                    errors++;
                    $display("FAIL gap_order[%0d]: got %0d expected %0d", i, obs_q[i], i + 1);
                end
            end
            checks++;
            if (obs_cyc[0] != p + 1) begin
                errors++;
                $display("FAIL gap_first_latency: got %0d expected %0d", obs_cyc[0] - p, 1);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != GAP + 2) begin
                    errors++;
                    $display("FAIL gap_spacing[%0d]: got %0d expected %0d", i, obs_cyc[i] - obs_cyc[i-1], GAP + 2);
                end
            end
        end
        checks++;
        if (bus.count !== 4'd0) begin
            errors++;
            $display("FAIL gap_final_count: got %0d expected 0", bus.count);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_q[$];
        logic [2:0] c;
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            c            = 3'($urandom_range(1, 7));
            bus.push     = 1'b1;
            bus.push_cmd = c;
            if (exp_q.size() < DEPTH) exp_q.push_back(c);
            tick();
        end
        bus.push = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 4'(DEPTH) || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got full=%b count=%0d ovf=%b expected 1 %0d 1",
                     bus.full, bus.count, bus.overflow, DEPTH);
        end
        bus.busy = 1'b0;
        repeat (60) tick();
        checks++;
        if (obs_q.size() != DEPTH) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d strobes expected %0d", obs_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ovf_order[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (bus.count !== 4'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got count=%0d full=%b ovf=%b expected 0 0 1", bus.count, bus.full, bus.overflow);
        end
    endtask

    task automatic test_write_done();
        int s;
        bit ok;
        apply_reset();
        bus.busy = 1'b0;
        tick();
        bus.push = 1'b1; bus.push_cmd = 3'd5; tick();
        bus.push = 1'b1; bus.push_cmd = 3'd0; tick();
        bus.push = 1'b0;
        wait_strobe(40, 1'b1, s, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wd_write_strobe: got none expected write strobe within 40 cycles");
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 3'd5 || obs_q[1] !== 3'd0) begin
            errors++;
            $display("FAIL wd_sequence: got %0d strobes expected 5 then 0", obs_q.size());
        end
        for (int k = 1; k <= 11; k++) begin
            bus.busy = (k <= 10);
            tick();
        end
        checks++;
        if (bus.finished !== 1'b0) begin
            errors++;
            $display("FAIL wd_early_finished: got %b expected 0", bus.finished);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.finished !== 1'b1 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_finished: got fin=%b to=%b expected 1 0", bus.finished, bus.timeout);
        end
        bus.push = 1'b1; bus.push_cmd = 3'd6; tick();
        bus.push = 1'b0;
        repeat (20) tick();
        checks++;
        if (obs_q.size() != 2 || bus.count !== 4'd1) begin
            errors++;
            $display("FAIL wd_halt: got strobes=%0d count=%0d expected 2 1", obs_q.size(), bus.count);
        end
    endtask

    task automatic test_timeout(input bit tie_done);
        int s;
        bit ok;
        apply_reset();
        bus.busy = 1'b0;
        tick();
        bus.push = 1'b1; bus.push_cmd = 3'd0; tick();
        bus.push = 1'b0;
        wait_strobe(20, 1'b1, s, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_write_strobe: got none expected write strobe within 20 cycles");
        end
        repeat (TIMEOUT - 1) tick();
        checks++;
        if (bus.timeout !== 1'b0 || bus.finished !== 1'b0) begin
            errors++;
            $display("FAIL to_early: got to=%b fin=%b at %0d cycles expected 0 0", bus.timeout, bus.finished, cyc - s);
        end
        bus.done = tie_done;
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.timeout !== !tie_done || bus.finished !== tie_done) begin
            errors++;
            $display("FAIL to_terminal(tie=%0d): got to=%b fin=%b at %0d cycles expected to=%b fin=%b",
                     tie_done, bus.timeout, bus.finished, cyc - s, !tie_done, tie_done);
        end
    endtask

    task automatic test_reset_in_gap();
        int s;
        bit ok;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.push = 1'b1; bus.push_cmd = 3'($urandom_range(1, 7)); tick();
        end
        bus.push = 1'b0;
        bus.busy = 1'b0;
        wait_strobe(20, 1'b0, s, ok);
        tick();
        checks++;
        if (!ok || bus.count !== 4'd3) begin
            errors++;
            $display("FAIL rg_setup: got strobe=%0d count=%0d expected 1 3", ok, bus.count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== 4'd0 || {bus.cmd_valid, bus.cmd, bus.full, bus.overflow, bus.finished, bus.timeout} !== 8'd0) begin
            errors++;
            $display("FAIL rg_async_clear: got count=%0d vld=%b cmd=%0d expected 0 0 0", bus.count, bus.cmd_valid, bus.cmd);
        end
        bus.busy = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        prev_valid = 1'b0;
        prev_cmd   = 3'd0;
        bus.push = 1'b1; bus.push_cmd = 3'd7; tick();
        bus.push = 1'b0;
        tick();
        bus.busy = 1'b0;
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rg_wait_ready: got vld=%b expected 0", bus.cmd_valid);
        end
        tick();
        checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd !== 3'd7) begin
            errors++;
            $display("FAIL rg_restart: got vld=%b cmd=%0d expected 1 7", bus.cmd_valid, bus.cmd);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_q[$];
        int         left      = DEPTH;
        int         stall_err = 0;
        int         nbefore;
        logic       busy_drv;
        apply_reset();
        bus.busy = 1'b0;
        tick();
        for (int i = 0; i < 150; i++) begin
            bus.busy = ($urandom_range(0, 3) == 0);
            bus.push = (left > 0) && ($urandom_range(0, 2) == 0);
            bus.push_cmd = 3'($urandom_range(1, 7));
            if (bus.push) begin
                exp_q.push_back(bus.push_cmd);
                left--;
            end
            busy_drv = bus.busy;
            nbefore  = obs_q.size();
            tick();
            if (obs_q.size() > nbefore && busy_drv) stall_err++;
        end
        bus.push = 1'b0;
        bus.busy = 1'b0;
        repeat (40) tick();
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL rnd_busy_stall: got %0d strobes on busy cycles expected 0", stall_err);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_order[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (bus.count !== 4'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rnd_final: got count=%0d ovf=%b expected 0 0", bus.count, bus.overflow);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_err != 0) begin
            errors++;
            $display("FAIL strobe_rules: got %0d double-strobe or off-issue cmd changes expected 0", inv_err);
        end
    endtask

    initial begin
        test_reset();
        test_busy_hold();
        test_gap();
        test_overflow();
        test_write_done();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_in_gap();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
